// File: rtl/forwarding_unit.sv
// Operand forwarding control for the 5-stage pipeline: picks the ALU operand
// sources (register file, EX/MEM or MEM/WB) and registers the selects.

module forwarding_sel #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] ars,
  input  logic [ADDR_W-1:0] ard_ex_mem,
  input  logic [ADDR_W-1:0] ard_mem_wb,
  input  logic              regwrite_ex_mem,
  input  logic              regwrite_mem_wb,
  output logic [1:0]        sel
);
  logic ex_hit, mem_hit;

  // x0 is hard-wired zero, so a write to it never produces forwardable data.
  assign ex_hit  = regwrite_ex_mem && (ard_ex_mem != '0) && (ard_ex_mem == ars);
  assign mem_hit = regwrite_mem_wb && (ard_mem_wb != '0) && (ard_mem_wb == ars);

  always_comb begin
    sel = 2'b00;
    if (ex_hit)       sel = 2'b10;
    else if (mem_hit) sel = 2'b01;
  end
endmodule

module forwarding_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ard_ex_mem,
  input  logic [ADDR_W-1:0] ard_mem_wb,
  input  logic [ADDR_W-1:0] ars1,
  input  logic [ADDR_W-1:0] ars2,
  input  logic              regwrite_ex_mem,
  input  logic              regwrite_mem_wb,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);
  localparam int NUM_OPS = 2;

  logic [NUM_OPS-1:0][ADDR_W-1:0] ars_vec;
  logic [NUM_OPS-1:0][1:0]        sel_nxt;

  assign ars_vec = {ars2, ars1};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      forwarding_sel #(.ADDR_W(ADDR_W)) u_sel (
        .ars             (ars_vec[g]),
        .ard_ex_mem      (ard_ex_mem),
        .ard_mem_wb      (ard_mem_wb),
        .regwrite_ex_mem (regwrite_ex_mem),
        .regwrite_mem_wb (regwrite_mem_wb),
        .sel             (sel_nxt[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      forward_a <= 2'b00;
      forward_b <= 2'b00;
    end else begin
      forward_a <= sel_nxt[0];
      forward_b <= sel_nxt[1];
    end
  end
endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: a rule-level model checked every cycle,
// plus literal expectations per vector.

module tb_forwarding_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ard_ex_mem, ard_mem_wb, ars1, ars2;
  logic       regwrite_ex_mem, regwrite_mem_wb;
  logic [1:0] forward_a, forward_b;

  int n_tests = 0;
  int n_fail  = 0;

  forwarding_unit #(.ADDR_W(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ard_ex_mem      (ard_ex_mem),
    .ard_mem_wb      (ard_mem_wb),
    .ars1            (ars1),
    .ars2            (ars2),
    .regwrite_ex_mem (regwrite_ex_mem),
    .regwrite_mem_wb (regwrite_mem_wb),
    .forward_a       (forward_a),
    .forward_b       (forward_b)
  );

  always #5 clk = ~clk;

  // Which stage holds the newest value of register rs, as an operand select.
  function automatic logic [1:0] model_sel(int rs, int ex_rd, int wb_rd, bit ex_we, bit wb_we);
    if (rs == 0) return 2'b00;
    if (ex_we && ex_rd == rs) return 2'b10;
    if (wb_we && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  logic [1:0] exp_a, exp_b;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_a <= 2'b00;
      exp_b <= 2'b00;
      model_valid <= 1'b1;
    end else begin
      exp_a <= model_sel(ars1, ard_ex_mem, ard_mem_wb, regwrite_ex_mem, regwrite_mem_wb);
      exp_b <= model_sel(ars2, ard_ex_mem, ard_mem_wb, regwrite_ex_mem, regwrite_mem_wb);
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_a", forward_a, exp_a);
      chk("model_b", forward_b, exp_b);
    end
  end

  typedef struct {
    string      name;
    logic [4:0] ex_rd, wb_rd, rs1, rs2;
    logic       ex_we, wb_we;
    logic [1:0] ea, eb;
  } vec_t;

  vec_t vecs[$];

  task automatic apply(input vec_t v);
    @(negedge clk);
    ard_ex_mem = v.ex_rd; ard_mem_wb = v.wb_rd;
    ars1 = v.rs1; ars2 = v.rs2;
    regwrite_ex_mem = v.ex_we; regwrite_mem_wb = v.wb_we;
    @(posedge clk); #1;
    chk({v.name, "_a"}, forward_a, v.ea);
    chk({v.name, "_b"}, forward_b, v.eb);
    chk({v.name, "_model_a"}, exp_a, v.ea);
    chk({v.name, "_model_b"}, exp_b, v.eb);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ard_ex_mem = 5'd3; ard_mem_wb = 5'd0; ars1 = 5'd3; ars2 = 5'd0;
    regwrite_ex_mem = 1'b1; regwrite_mem_wb = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_a", forward_a, 2'b00);
      chk("reset_b", forward_b, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_a", forward_a, 2'b10);
    chk("release_b", forward_b, 2'b00);

    vecs.push_back('{"no_hazard",   5'd1,  5'd2,  5'd3, 5'd4,  1'b0, 1'b0, 2'b00, 2'b00});
    vecs.push_back('{"ex_rs1",      5'd3,  5'd2,  5'd3, 5'd5,  1'b1, 1'b0, 2'b10, 2'b00});
    vecs.push_back('{"ex_rs1_nowe", 5'd3,  5'd2,  5'd3, 5'd5,  1'b0, 1'b0, 2'b00, 2'b00});
    vecs.push_back('{"ex_rs2",      5'd5,  5'd2,  5'd3, 5'd5,  1'b1, 1'b0, 2'b00, 2'b10});
    vecs.push_back('{"wb_rs1",      5'd1,  5'd7,  5'd7, 5'd8,  1'b0, 1'b1, 2'b01, 2'b00});
    vecs.push_back('{"wb_rs2",      5'd1,  5'd8,  5'd7, 5'd8,  1'b0, 1'b1, 2'b00, 2'b01});
    vecs.push_back('{"wb_rs1_nowe", 5'd1,  5'd7,  5'd7, 5'd8,  1'b0, 1'b0, 2'b00, 2'b00});
    vecs.push_back('{"wb_rs2_nowe", 5'd1,  5'd8,  5'd7, 5'd8,  1'b0, 1'b0, 2'b00, 2'b00});
    vecs.push_back('{"double",      5'd9,  5'd10, 5'd9, 5'd10, 1'b1, 1'b1, 2'b10, 2'b01});
    vecs.push_back('{"priority",    5'd6,  5'd6,  5'd6, 5'd6,  1'b1, 1'b1, 2'b10, 2'b10});
    vecs.push_back('{"x0",          5'd0,  5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 2'b00, 2'b00});
    vecs.push_back('{"x0_wb_only",  5'd0,  5'd4,  5'd0, 5'd4,  1'b1, 1'b1, 2'b00, 2'b01});
    vecs.push_back('{"wb_both",     5'd2,  5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 2'b01, 2'b01});
    vecs.push_back('{"ex_nowe_wb",  5'd12, 5'd12, 5'd12, 5'd1, 1'b0, 1'b1, 2'b01, 2'b00});

    foreach (vecs[i]) apply(vecs[i]);

    // Reset must win over a live match.
    @(negedge clk);
    ard_ex_mem = 5'd6; ars1 = 5'd6; ars2 = 5'd6; regwrite_ex_mem = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_wins_a", forward_a, 2'b00);
    chk("reset_wins_b", forward_b, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_a", forward_a, 2'b10);
    chk("post_reset_b", forward_b, 2'b10);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
